// File: rtl/csr_uart_rx.sv
// CSR-mapped 8N1 UART receiver with a small byte FIFO.
// Data register pops on read; status register holds flags and the FIFO count.
module csr_uart_rx #(
  parameter logic [11:0] BASE_ADDR  = 12'hBC0,
  parameter int          CLK_DIV    = 8,
  parameter int          DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  input  logic        rx,
  output logic        irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(CLK_DIV);
  localparam int CNT_W = DEPTH_LOG2 + 1;

  localparam logic [11:0]   STAT_ADDR = BASE_ADDR + 12'd1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

  // ---------------------------------------------------------------------------
  // rx synchronizer
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       rx_s;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  end

  assign rx_s = sync_q[1];

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_e        state_q;
  logic [CW-1:0] cyc_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tick;
  logic          push_req;
  logic          frame_err;

  assign tick      = (cyc_q == '0);
  assign push_req  = (state_q == STOP) && tick && rx_s;
  assign frame_err = (state_q == STOP) && tick && !rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            cyc_q   <= HALF_LOAD;
            bit_q   <= '0;
          end
        end
        START: begin
          if (!tick)     cyc_q   <= cyc_q - CW'(1);
          else if (rx_s) state_q <= IDLE;
          else begin
            state_q <= DATA;
            cyc_q   <= FULL_LOAD;
          end
        end
        DATA: begin
          if (!tick) cyc_q <= cyc_q - CW'(1);
          else begin
            shift_q <= {rx_s, shift_q[7:1]};
            cyc_q   <= FULL_LOAD;
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= STOP;
          end
        end
        STOP: begin
          if (!tick) cyc_q   <= cyc_q - CW'(1);
          else       state_q <= rx_s ? IDLE : WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // CSR address phase and decode
  // ---------------------------------------------------------------------------
  logic [11:0] addr_q;
  logic        sel_data;
  logic        sel_stat;
  logic        wr_op;

  always_ff @(posedge clk) begin
    if (rst) addr_q <= '0;
    else     addr_q <= addr;
  end

  assign valid    = (addr == BASE_ADDR) || (addr == STAT_ADDR);
  assign sel_data = (addr_q == BASE_ADDR);
  assign sel_stat = (addr_q == STAT_ADDR);
  assign wr_op    = (modify == 3'd1) || (modify == 3'd3);

  // ---------------------------------------------------------------------------
  // Receive FIFO and flags
  // ---------------------------------------------------------------------------
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  ovr_q;
  logic                  ferr_q;
  logic                  empty;
  logic                  full;
  logic                  pop;
  logic                  do_push;
  logic                  ovr_set;
  logic                  clr_ovr;
  logic                  clr_ferr;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign pop      = read && sel_data && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push  = push_req && (!full || pop);
  assign ovr_set  = push_req && full && !pop;
  assign clr_ovr  = sel_stat && wr_op && wdata[1];
  assign clr_ferr = sel_stat && wr_op && wdata[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      case ({do_push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      ovr_q  <= ovr_set   | (ovr_q  & ~clr_ovr);
      ferr_q <= frame_err | (ferr_q & ~clr_ferr);
    end
  end

  // NOTE: the storage array has no reset; the count and pointers alone decide
  // which entries are meaningful, so resetting it would only cost flops.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= shift_q;
  end

  // ---------------------------------------------------------------------------
  // Read data (OR-bus: zero when not selected)
  // ---------------------------------------------------------------------------
  logic [31:0] status_w;

  always_comb begin
    status_w                    = '0;
    status_w[0]                 = !empty;
    status_w[1]                 = ovr_q;
    status_w[2]                 = ferr_q;
    status_w[DEPTH_LOG2+3:3]    = count_q;
    rdata                       = '0;
    if (sel_data)      rdata = empty ? 32'hFFFF_FFFF : {24'h0, mem_q[rd_ptr_q]};
    else if (sel_stat) rdata = status_w;
  end

  assign irq = !empty;

  logic unused_wdata;
  assign unused_wdata = ^{wdata[31:3], wdata[0]};

endmodule

// File: tb/tb_csr_uart_rx.sv
// Directed and randomized checks of csr_uart_rx against a queue-based model
// of the receive FIFO and its status flags.
module tb_csr_uart_rx;

  localparam logic [11:0] BASE    = 12'hBC0;
  localparam logic [11:0] STAT    = 12'hBC1;
  localparam int          CLK_DIV = 8;
  localparam int          DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        read;
  logic [2:0]  modify;
  logic [31:0] wdata;
  logic [11:0] addr;
  logic [31:0] rdata;
  logic        valid;
  logic        rx;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  m_q[$];
  logic        m_ovr;
  logic        m_ferr;
  logic [31:0] v;
  logic [31:0] exp_v;

  csr_uart_rx #(.BASE_ADDR(BASE), .CLK_DIV(CLK_DIV), .DEPTH_LOG2(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .read   (read),
    .modify (modify),
    .wdata  (wdata),
    .addr   (addr),
    .rdata  (rdata),
    .valid  (valid),
    .rx     (rx),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural model: a byte queue plus two sticky flags.
  function automatic void model_reset();
    m_q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endfunction

  function automatic void model_rx(input logic [7:0] b, input logic stop_v);
    if (!stop_v)               m_ferr = 1'b1;
    else if (m_q.size() == DEPTH) m_ovr  = 1'b1;
    else                       m_q.push_back(b);
  endfunction

  function automatic logic [31:0] model_data(input logic do_pop);
    logic [31:0] r;
    if (m_q.size() == 0) r = 32'hFFFF_FFFF;
    else begin
      r = {24'h0, m_q[0]};
      if (do_pop) void'(m_q.pop_front());
    end
    return r;
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s    = 32'(m_q.size()) << 3;
    s[0] = (m_q.size() != 0);
    s[1] = m_ovr;
    s[2] = m_ferr;
    return s;
  endfunction

  task automatic csr(input logic [11:0] a, input logic rd, input logic [2:0] md,
                     input logic [31:0] wd, output logic [31:0] rv);
    @(negedge clk);
    addr = a; read = 1'b0; modify = 3'd0; wdata = '0;
    @(negedge clk);
    addr = 12'h000; read = rd; modify = md; wdata = wd;
    rv = rdata;
    @(negedge clk);
    read = 1'b0; modify = 3'd0; wdata = '0;
  endtask

  task automatic read_data(input string tag);
    logic [31:0] r;
    csr(BASE, 1'b1, 3'd0, '0, r);
    check(tag, r, model_data(1'b1));
  endtask

  task automatic read_status(input string tag);
    logic [31:0] r;
    csr(STAT, 1'b1, 3'd0, '0, r);
    check(tag, r, model_status());
    check({tag, "_irq"}, 32'(irq), 32'(m_q.size() != 0));
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int extra_low);
    @(negedge clk);
    rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    rx = stop_v;
    repeat (CLK_DIV + extra_low) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; read = 1'b0; modify = 3'd0; wdata = '0; addr = 12'h000;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_valid_unmapped", 32'(valid), 32'd0);
    addr = BASE;
    @(negedge clk);
    check("rst_rdata_sel", rdata, 32'd0);
    check("valid_data", 32'(valid), 32'd1);
    addr = STAT;
    #1 check("valid_stat", 32'(valid), 32'd1);
    rst = 1'b0;
    addr = 12'h000;

    // Empty FIFO and unmapped address
    read_data("empty_data");
    read_status("empty_status");
    @(negedge clk);
    addr = 12'h123;
    #1 check("valid_123", 32'(valid), 32'd0);
    csr(12'h123, 1'b1, 3'd0, '0, v);
    check("rdata_123", v, 32'd0);

    // Single byte 0x55
    send_frame(8'h55, 1'b1, 0);
    model_rx(8'h55, 1'b1);
    read_status("s55_status");
    read_data("s55_data");
    read_status("s55_after");

    // Five bytes into a four-entry FIFO
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 0);
      model_rx(8'(i), 1'b1);
    end
    read_status("ovr_status");
    csr(BASE, 1'b0, 3'd0, '0, v);
    check("peek_no_pop", v, model_data(1'b0));
    read_status("peek_status");
    for (int i = 0; i < 5; i++) read_data("ovr_drain");
    csr(STAT, 1'b0, 3'd2, 32'h2, v);
    read_status("mod2_noeffect");
    csr(BASE, 1'b0, 3'd1, 32'h2, v);
    read_status("data_write_ignored");
    csr(STAT, 1'b0, 3'd3, 32'h2, v);
    m_ovr = 1'b0;
    read_status("ovr_cleared");

    // Framing error: 0xA5 with low stop bit, line held low three more bits
    send_frame(8'hA5, 1'b0, 3 * CLK_DIV);
    model_rx(8'hA5, 1'b0);
    read_status("ferr_status");
    csr(STAT, 1'b0, 3'd1, 32'h4, v);
    m_ferr = 1'b0;
    read_status("ferr_cleared");

    // Glitch shorter than half a bit
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CLK_DIV) @(negedge clk);
    read_status("glitch_status");
    send_frame(8'h3C, 1'b1, 0);
    model_rx(8'h3C, 1'b1);
    read_status("post_glitch_status");
    read_data("post_glitch_data");

    // Full FIFO: pop coinciding with the stop-bit push of 0x7E
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      send_frame(b, 1'b1, 0);
      model_rx(b, 1'b1);
    end
    read_status("full_status");
    fork
      send_frame(8'h7E, 1'b1, 0);
      begin
        @(negedge clk);
        repeat (77) @(negedge clk);
        addr = BASE;
        @(negedge clk);
        addr = 12'h000;
        read = 1'b1;
        v = rdata;
        @(negedge clk);
        read = 1'b0;
      end
    join
    check("coincide_pop_data", v, model_data(1'b1));
    model_rx(8'h7E, 1'b1);
    read_status("coincide_status");
    for (int i = 0; i < DEPTH + 1; i++) read_data("coincide_drain");

    // Reset in the middle of a frame
    send_frame(8'h11, 1'b1, 0);
    model_rx(8'h11, 1'b1);
    read_status("pre_reset_status");
    fork
      send_frame(8'hFF, 1'b1, 0);
      begin
        repeat (40) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    join
    model_reset();
    read_status("midframe_reset_status");
    send_frame(8'h42, 1'b1, 0);
    model_rx(8'h42, 1'b1);
    read_data("post_reset_data");

    // Randomized frames, reads and flag clears
    for (int n = 0; n < 12; n++) begin
      logic [7:0] b;
      logic       stop_v;
      int         nreads;
      b      = 8'($urandom);
      stop_v = ($urandom_range(0, 4) != 0);
      send_frame(b, stop_v, 0);
      model_rx(b, stop_v);
      read_status("rand_status");
      nreads = int'($urandom_range(0, 2));
      for (int k = 0; k < nreads; k++) read_data("rand_data");
      if ($urandom_range(0, 1) == 1) begin
        exp_v = 32'($urandom_range(0, 3)) << 1;
        csr(STAT, 1'b0, 3'd1, exp_v, v);
        if (exp_v[1]) m_ovr  = 1'b0;
        if (exp_v[2]) m_ferr = 1'b0;
        read_status("rand_clear");
      end
    end
    for (int i = 0; i < DEPTH + 1; i++) read_data("final_drain");
    read_status("final_status");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
